// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage and its data-alignment helper.
package mem_access_stage_pkg;

  localparam int BE_W = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mem_access_stage_align.sv
// Combinational load extract/extend and store replicate/byte-enable generation.
module mem_data_align
  import mem_access_stage_pkg::*;
(
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [31:0]     store_data,
  input  logic [31:0]     load_word,
  output logic [31:0]     load_data,
  output logic [31:0]     store_wdata,
  output logic [BE_W-1:0] be,
  output logic            illegal,
  output logic            misaligned
);

  logic [31:0] byte_shift;
  logic [31:0] half_shift;

  assign byte_shift = load_word >> {addr_lo, 3'b000};
  assign half_shift = load_word >> {addr_lo[1], 4'b0000};

  always_comb begin
    load_data = '0;
    case (funct3)
      F3_B:    load_data = {{24{byte_shift[7]}}, byte_shift[7:0]};
      F3_H:    load_data = {{16{half_shift[15]}}, half_shift[15:0]};
      F3_W:    load_data = load_word;
      F3_BU:   load_data = {24'd0, byte_shift[7:0]};
      F3_HU:   load_data = {16'd0, half_shift[15:0]};
      default: load_data = '0;
    endcase
  end

  // Size lives in funct3[1:0] for both loads and stores.
  always_comb begin
    store_wdata = store_data;
    be          = '1;
    case (funct3[1:0])
      2'b00: begin
        store_wdata = {4{store_data[7:0]}};
        be          = BE_W'(1) << addr_lo;
      end
      2'b01: begin
        store_wdata = {2{store_data[15:0]}};
        be          = BE_W'(3) << addr_lo;
      end
      default: begin
        store_wdata = store_data;
        be          = '1;
      end
    endcase
  end

  always_comb begin
    if (is_store)
      illegal = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W);
    else
      illegal = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W ||
                  funct3 == F3_BU || funct3 == F3_HU);
  end

  assign misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                      ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));

endmodule

// File: rtl/mem_access_stage.sv
// RISC-V MEM stage: req/ack data-memory sequencing, stall generation and MEM/WB register.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int AW      = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [31:0]     alu_result_i,
  input  logic [31:0]     rd_data_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            reg_write_i,
  input  logic            mem_to_reg_i,
  input  logic            mem_read_i,
  input  logic            mem_write_i,
  input  logic [31:0]     instr_i,
  output logic            stall_o,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [AW-1:0]   dmem_addr_o,
  output logic [BE_W-1:0] dmem_be_o,
  output logic [31:0]     dmem_wdata_o,
  input  logic            dmem_ack_i,
  input  logic [31:0]     dmem_rdata_i,
  output logic [31:0]     wb_data_o,
  output logic [4:0]      wb_rd_addr_o,
  output logic            wb_reg_write_o,
  output logic [31:0]     wb_instr_o,
  output logic            misalign_o,
  output logic            bus_err_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e      state;
  logic [CW-1:0] cnt;
  logic [31:0] rdata_hold;
  logic        timed_out;

  logic        mem_op;
  logic        illegal;
  logic        misaligned;
  logic        launch;
  logic [31:0] load_data;
  logic [31:0] store_wdata;
  logic [BE_W-1:0] be;

  assign mem_op = mem_read_i | mem_write_i;

  mem_data_align u_align (
    .is_store    (mem_write_i),
    .funct3      (instr_i[14:12]),
    .addr_lo     (alu_result_i[1:0]),
    .store_data  (rd_data_i),
    .load_word   (rdata_hold),
    .load_data   (load_data),
    .store_wdata (store_wdata),
    .be          (be),
    .illegal     (illegal),
    .misaligned  (misaligned)
  );

  assign launch       = (state == ST_IDLE) && mem_op && !illegal && !misaligned;
  assign dmem_req_o   = !rst_i && (launch || (state == ST_BUSY));
  assign stall_o      = dmem_req_o;
  assign dmem_we_o    = dmem_req_o && mem_write_i;
  assign dmem_addr_o  = {alu_result_i[AW-1:2], 2'b00};
  assign dmem_be_o    = be;
  assign dmem_wdata_o = store_wdata;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      rdata_hold     <= '0;
      timed_out      <= 1'b0;
      wb_data_o      <= '0;
      wb_rd_addr_o   <= '0;
      wb_reg_write_o <= 1'b0;
      wb_instr_o     <= '0;
      misalign_o     <= 1'b0;
      bus_err_o      <= 1'b0;
    end else begin
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!mem_op || illegal || misaligned) begin
            wb_data_o      <= alu_result_i;
            wb_rd_addr_o   <= rd_addr_i;
            wb_reg_write_o <= reg_write_i && !mem_op;
            wb_instr_o     <= instr_i;
            misalign_o     <= mem_op && misaligned && !illegal;
            bus_err_o      <= mem_op && illegal;
          end else begin
            wb_data_o      <= '0;
            wb_rd_addr_o   <= '0;
            wb_reg_write_o <= 1'b0;
            wb_instr_o     <= '0;
            timed_out      <= 1'b0;
            if (dmem_ack_i) begin
              rdata_hold <= dmem_rdata_i;
              state      <= ST_DONE;
            end else if (TIMEOUT == 1) begin
              rdata_hold <= '0;
              timed_out  <= 1'b1;
              bus_err_o  <= 1'b1;
              state      <= ST_DONE;
            end else begin
              // The launch cycle already counts as one wait cycle.
              cnt   <= CW'(1);
              state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          wb_data_o      <= '0;
          wb_rd_addr_o   <= '0;
          wb_reg_write_o <= 1'b0;
          wb_instr_o     <= '0;
          if (dmem_ack_i) begin
            rdata_hold <= dmem_rdata_i;
            cnt        <= '0;
            state      <= ST_DONE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            rdata_hold <= '0;
            timed_out  <= 1'b1;
            bus_err_o  <= 1'b1;
            cnt        <= '0;
            state      <= ST_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DONE: begin
          wb_data_o      <= mem_to_reg_i ? load_data : alu_result_i;
          wb_rd_addr_o   <= rd_addr_i;
          wb_reg_write_o <= reg_write_i && !timed_out;
          wb_instr_o     <= instr_i;
          state          <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the RISC-V pipeline. Consumes the EX/MEM pipeline register outputs and drives a req/ack data-memory port.
- Formats load data (byte/half/word, sign/zero extension) and replicates store data with byte enables.
- Asserts stall_o back to the EX/MEM register's Stall input while an access is in flight.
- Contains the MEM/WB output register; a bubble is inserted while stalled.

Parameters:
- TIMEOUT, 16, ack wait cycles in BUSY before abort (≥1).
- AW, 32, data address width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- alu_result_i  in  32  effective address, or ALU result for non-memory ops.
- rd_data_i  in  32  store data (rs2).
- rd_addr_i  in  5  destination register.
- reg_write_i, mem_to_reg_i, mem_read_i, mem_write_i  in  1 each  control bits from EX/MEM.
- instr_i  in  32  instruction; funct3 = instr_i[14:12].
- stall_o  out  1  holds EX/MEM and upstream stages.
- dmem_req_o  out  1  access request.
- dmem_we_o  out  1  1 = store.
- dmem_addr_o  out  AW  word-aligned address, low two bits forced to 0.
- dmem_be_o  out  4  byte enables.
- dmem_wdata_o  out  32  store data.
- dmem_ack_i  in  1  access complete, one-cycle pulse.
- dmem_rdata_i  in  32  read word, valid with ack.
- wb_data_o  out  32  MEM/WB register: result to write back.
- wb_rd_addr_o  out  5  MEM/WB register: destination register.
- wb_reg_write_o  out  1  MEM/WB register: write enable.
- wb_instr_o  out  32  MEM/WB register: instruction.
- misalign_o  out  1  registered one-cycle pulse: misaligned access dropped.
- bus_err_o  out  1  registered one-cycle pulse: timeout or illegal funct3.

Behaviour:
- mem_op = mem_read_i | mem_write_i; a store takes priority if both bits are set.
- Reset (next edge while rst_i=1):
  - FSM goes to IDLE; timeout counter cleared.
  - All wb_* outputs, misalign_o and bus_err_o go to 0.
  - dmem_req_o and stall_o go to 0 combinationally.
- Reset mid-access abandons the access; any later ack is ignored.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other funct3 on a mem_op is illegal.
- Misalignment: half access with addr[0]≠0, or word access with addr[1:0]≠0.
- FSM states: IDLE, BUSY, DONE.
- IDLE, no mem_op:
  - stall_o=0.
  - MEM/WB loads wb_data=alu_result_i, wb_rd_addr=rd_addr_i, wb_reg_write=reg_write_i, wb_instr=instr_i.
- IDLE, mem_op that is misaligned or illegal:
  - No request issued; stall_o=0.
  - MEM/WB loads wb_reg_write=0.
  - misalign_o or bus_err_o pulses on the next cycle.
- IDLE, legal mem_op:
  - dmem_req_o=1 and stall_o=1 combinationally.
  - If ack arrives the same cycle, capture data and go to DONE; otherwise go to BUSY.
  - MEM/WB loads a bubble (wb_reg_write=0).
- BUSY:
  - dmem_req_o=1, stall_o=1; address, data and be held stable; counter increments; MEM/WB loads a bubble.
  - On ack: capture rdata into the hold register, clear the counter, go to DONE.
  - When the counter reaches TIMEOUT-1 with no ack: drop req, hold data = 0, bus_err_o pulses, go to DONE.
- DONE:
  - stall_o=0, dmem_req_o=0.
  - MEM/WB loads wb_data = formatted load data if mem_to_reg_i, else alu_result_i. wb_reg_write = reg_write_i, or 0 after a timeout.
  - Next state is IDLE.
- Latency: with an immediate ack, exactly one stall cycle; the result is visible in MEM/WB 2 edges after the op is presented.
- Load format:
  - Select the byte or half by addr[1:0] or addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Store format:
  - SB: wdata = byte replicated ×4, be = 0001 << addr[1:0].
  - SH: wdata = half replicated ×2, be = 0011 << addr[1:0].
  - SW: be = 1111.
- Load accesses drive be per size as well; memory may ignore it.
- Ack outside IDLE/BUSY is ignored.

Decomposition:
- Shared package holds:
  - funct3 constants F3_B/H/W/BU/HU.
  - FSM state encoding.
  - Byte-enable width constant.
- One natural sub-module: mem_data_align. It is combinational: load extract/extend and store replicate/be generation, shared with any future LSU.

Test Plan:
- LW at 0x100, ack in the same cycle, rdata=0xDEADBEEF → stall_o high for 1 cycle; wb_data_o=0xDEADBEEF, wb_reg_write_o=1 two edges after the op.
- LB at 0x103, rdata=0x80112233, ack after 3 cycles → 3 stall cycles; wb_data_o=0xFFFFFF80. Repeat as LBU → 0x00000080.
- SH at 0x102 with rd_data_i=0x0000ABCD → dmem_be_o=1100, dmem_wdata_o=0xABCDABCD, dmem_addr_o=0x100, we=1.
- LW at 0x101 → no dmem_req_o, stall_o=0, misalign_o pulses once, wb_reg_write_o=0.
- LW with ack never arriving, TIMEOUT=16 → stall_o high for exactly 16 cycles, bus_err_o pulses, wb_reg_write_o=0. A late ack afterwards is ignored.
- rst_i asserted during BUSY → next edge FSM is IDLE, dmem_req_o=0, all wb_* outputs 0.
